aes_sub_bytes_serial: RTL and testbench

Byte-serial forward SubBytes engine for the ultraserial AES datapath. It accepts an N-byte state block over a valid/ready handshake and substitutes one byte per cycle through a single forward S-box instance. It returns the result over a second valid/ready handshake. It is the encrypt-direction counterpart of the existing inverse S-box path, and is reused with NUM_BYTES=4 as SubWord in key expansion.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_sub_bytes_serial.sv | 95 +++++++++
 tb/tb_aes_sub_bytes_serial.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants and engine state encoding
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box (FIPS-197 table)
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_sub_bytes_serial.sv
// rtl/aes_sub_bytes_serial.sv - byte-serial forward SubBytes engine, one S-box lookup per cycle
module aes_sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = AES_STATE_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy
);

  localparam int CNT_W = $clog2(NUM_BYTES);
  localparam int W     = 8 * NUM_BYTES;

  if (NUM_BYTES != AES_STATE_BYTES && NUM_BYTES != AES_WORD_BYTES) begin : g_bad_num_bytes
    $error("aes_sub_bytes_serial: NUM_BYTES must be 4 or 16");
  end

  sub_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     sreg_q;
  logic [W-1:0]     sreg_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [7:0]       sbox_out;

  aes_sbox u_sbox (
    .data_i (sreg_q[W-1 -: 8]),
    .data_o (sbox_out)
  );

  // Top byte leaves, its substitute enters at the bottom; NUM_BYTES rotates restore order.
  assign sreg_d = {sreg_q[W-9:0], sbox_out};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sreg_q     <= in_data;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          sreg_q <= sreg_d;
          if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
            cnt_q       <= '0;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = sreg_q;

endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// tb/tb_aes_sub_bytes_serial.sv - scoreboard bench for the 16-byte and 4-byte SubBytes engines
module tb_aes_sub_bytes_serial;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1, busy16;
  logic [127:0] in_data16 = '0, out_data16;
  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
  logic [31:0]  in_data4 = '0, out_data4;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   sb_tab  [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] exp16 [$], src16 [$];
  logic [127:0] exp4  [$], src4  [$];
  bit           prod_done;

  always #5 clk = ~clk;

  aes_sub_bytes_serial #(.NUM_BYTES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .busy(busy16)
  );

  aes_sub_bytes_serial #(.NUM_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden S-box built from GF(2^8) inversion plus the affine map, independent of the RTL table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_block(input logic [127:0] d, input int nb, input bit inv);
    logic [127:0] r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : sb_tab[d[8*i +: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      check_eq("sb16_pending", 128'(exp16.size() > 0), 128'd1);
      if (exp16.size() > 0) begin
        check_eq("sb16_data", out_data16, exp16.pop_front());
        check_eq("sb16_roundtrip", sub_block(out_data16, 16, 1'b1), src16.pop_front());
      end
    end
    if (!rst && out_valid4 && out_ready4) begin
      check_eq("sb4_pending", 128'(exp4.size() > 0), 128'd1);
      if (exp4.size() > 0) begin
        check_eq("sb4_data", 128'(out_data4), exp4.pop_front());
        check_eq("sb4_roundtrip", sub_block(128'(out_data4), 4, 1'b1), src4.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [127:0] d);
    bit acc = 1'b0;
    in_valid16 = 1'b1;
    in_data16  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready16) begin acc = 1'b1; break; end
    end
    if (acc) begin
      exp16.push_back(sub_block(d, 16, 1'b0));
      src16.push_back(d);
    end else begin
      check_eq("send16_accept", 128'(acc), 128'd1);
    end
    tick();
    in_valid16 = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d);
    bit acc = 1'b0;
    in_valid4 = 1'b1;
    in_data4  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready4) begin acc = 1'b1; break; end
    end
    if (acc) begin
      exp4.push_back(sub_block(128'(d), 4, 1'b0));
      src4.push_back(128'(d));
    end else begin
      check_eq("send4_accept", 128'(acc), 128'd1);
    end
    tick();
    in_valid4 = 1'b0;
  endtask

  // Called right after the accept edge; counts edges until out_valid and checks RUN controls.
  task automatic wait_valid(input string tag, input bit use4, input int lat);
    int cyc = 0;
    bit ctl_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc++;
      if (use4 ? out_valid4 : out_valid16) break;
      if ((use4 ? in_ready4 : in_ready16) || !(use4 ? busy4 : busy16)) ctl_ok = 1'b0;
    end
    check_eq({tag, "_latency"}, 128'(cyc), 128'(lat));
    check_eq({tag, "_run_ctl"}, 128'(ctl_ok), 128'd1);
    check_eq({tag, "_done_ctl"}, use4 ? {in_ready4, busy4} : {in_ready16, busy16}, 128'd0);
  endtask

  initial begin
    logic [127:0] b2;
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[sb_tab[i]] = 8'(i);

    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_in_ready16", 128'(in_ready16), 128'd1);
    check_eq("rst_out_valid16", 128'(out_valid16), 128'd0);
    check_eq("rst_busy16", 128'(busy16), 128'd0);
    check_eq("rst_out_data16", out_data16, 128'd0);
    check_eq("rst_ctl4", 128'({in_ready4, out_valid4, busy4}), 128'b100);

    send16(128'h0);
    wait_valid("zero16", 1'b0, 16);
    check_eq("zero16_data", out_data16, 128'h63636363636363636363636363636363);
    tick();

    send16(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    wait_valid("fips16", 1'b0, 16);
    check_eq("fips16_data", out_data16, 128'hd42711aee0bf98f1b8b45de51e415230);
    tick();

    send4(32'h09cf4f3c);
    wait_valid("word4a", 1'b1, 4);
    check_eq("word4a_data", 128'(out_data4), 128'h018a84eb);
    tick();
    send4(32'h00010253);
    wait_valid("word4b", 1'b1, 4);
    check_eq("word4b_data", 128'(out_data4), 128'h637c77ed);
    tick();

    out_ready16 = 1'b0;
    send16({4{32'hffffffff}});
    wait_valid("bp16", 1'b0, 16);
    b2 = {$urandom, $urandom, $urandom, $urandom};
    in_valid16 = 1'b1;
    in_data16  = b2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp16_stall_valid", 128'(out_valid16), 128'd1);
      check_eq("bp16_stall_data", out_data16, 128'h16161616161616161616161616161616);
      check_eq("bp16_stall_in_ready", 128'(in_ready16), 128'd0);
    end
    out_ready16 = 1'b1;
    tick();
    check_eq("bp16_release_ctl", 128'({in_ready16, out_valid16}), 128'b10);
    exp16.push_back(sub_block(b2, 16, 1'b0));
    src16.push_back(b2);
    tick();
    check_eq("bp16_second_accept", 128'({in_ready16, busy16}), 128'b01);
    in_valid16 = 1'b0;
    wait_valid("bp16b", 1'b0, 16);
    tick();

    send16({$urandom, $urandom, $urandom, $urandom});
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    exp16.delete();
    src16.delete();
    check_eq("midrst_ctl", 128'({in_ready16, out_valid16, busy16}), 128'b100);
    check_eq("midrst_data", out_data16, 128'd0);
    send16(128'h0);
    wait_valid("postrst16", 1'b0, 16);
    check_eq("postrst16_data", out_data16, 128'h63636363636363636363636363636363);
    tick();

    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send16({$urandom, $urandom, $urandom, $urandom});
          repeat ($urandom_range(0, 2)) tick();
        end
        prod_done = 1'b1;
      end
      begin
        for (int i = 0; i < 60000 && (!prod_done || exp16.size() != 0); i++) begin
          tick();
          out_ready16 = ($urandom_range(0, 3) != 0);
        end
        out_ready16 = 1'b1;
      end
    join
    check_eq("rand16_drained", 128'(exp16.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
